// File: rtl/alarm_fsm.sv
// Intruder-alarm controller: exit/entry delays, zone latching and one-shot
// set/reset commands for an external siren JK latch.
module alarm_fsm #(
   parameter int EXIT_CYC  = 16,
   parameter int ENTRY_CYC = 8
) (
   input  logic       clk,
   input  logic       clear,
   input  logic       arm,
   input  logic       code_ok,
   input  logic [3:0] sensor,
   output logic       j,
   output logic       k,
   output logic [2:0] state,
   output logic       armed,
   output logic       beep,
   output logic [3:0] zone
);

   typedef enum logic [2:0] {
      S_DISARMED = 3'd0,
      S_EXIT     = 3'd1,
      S_ARMED    = 3'd2,
      S_ENTRY    = 3'd3,
      S_ALARM    = 3'd4
   } state_t;

   localparam logic [7:0] EXIT_LOAD  = 8'(EXIT_CYC - 1);
   localparam logic [7:0] ENTRY_LOAD = 8'(ENTRY_CYC - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] zone_q, zone_d;
   logic       j_q, j_d;
   logic       k_q, k_d;
   logic [3:0] sync1_q, sync2_q;

   // Two-flop synchronizer; only sync2_q is ever seen by the FSM.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         sync1_q <= 4'd0;
         sync2_q <= 4'd0;
      end else begin
         sync1_q <= sensor;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_q <= S_DISARMED;
         cnt_q   <= 8'd0;
         zone_q  <= 4'd0;
         j_q     <= 1'b0;
         k_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         zone_q  <= zone_d;
         j_q     <= j_d;
         k_q     <= k_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      zone_d  = zone_q;
      case (state_q)
         S_DISARMED: begin
            if (arm) begin
               state_d = S_EXIT;
               cnt_d   = EXIT_LOAD;
               zone_d  = 4'd0;
            end
         end
         S_EXIT: begin
            if (code_ok) begin
               state_d = S_DISARMED;
            end else if (cnt_q == 8'd0) begin
               state_d = S_ARMED;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_ARMED: begin
            if (code_ok) begin
               state_d = S_DISARMED;
            end else if (sync2_q != 4'd0) begin
               state_d = S_ENTRY;
               cnt_d   = ENTRY_LOAD;
               zone_d  = zone_q | sync2_q;
            end
         end
         S_ENTRY: begin
            if (code_ok) begin
               state_d = S_DISARMED;
            end else begin
               zone_d = zone_q | sync2_q;
               if (cnt_q == 8'd0) begin
                  state_d = S_ALARM;
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
         end
         S_ALARM: begin
            if (code_ok) begin
               state_d = S_DISARMED;
            end else begin
               zone_d = zone_q | sync2_q;
            end
         end
         default: begin
            state_d = S_DISARMED;
            cnt_d   = 8'd0;
         end
      endcase
      // Siren commands fire only on the edges entering and leaving ALARM.
      j_d = (state_d == S_ALARM) && (state_q != S_ALARM);
      k_d = (state_d == S_DISARMED) && (state_q == S_ALARM);
   end

   assign state = state_q;
   assign armed = (state_q == S_ARMED) || (state_q == S_ENTRY);
   assign beep  = (state_q == S_EXIT) || (state_q == S_ENTRY);
   assign zone  = zone_q;
   assign j     = j_q;
   assign k     = k_q;

endmodule

// File: tb/tb_alarm_fsm.sv
// Bench for alarm_fsm: a delay-countdown model checked every cycle plus
// hand-computed expectations at key points of each scenario.
module tb_alarm_fsm;

   localparam int EXIT_CYC  = 4;
   localparam int ENTRY_CYC = 3;

   logic       clk = 1'b0;
   logic       clear = 1'b0;
   logic       arm = 1'b0;
   logic       code_ok = 1'b0;
   logic [3:0] sensor = 4'd0;
   logic       j, k, armed, beep;
   logic [2:0] state;
   logic [3:0] zone;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   alarm_fsm #(.EXIT_CYC(EXIT_CYC), .ENTRY_CYC(ENTRY_CYC)) dut (
      .clk(clk), .clear(clear), .arm(arm), .code_ok(code_ok), .sensor(sensor),
      .j(j), .k(k), .state(state), .armed(armed), .beep(beep), .zone(zone)
   );

   initial forever #5 clk = ~clk;

   // Model: mode 0..4, m_left = delay cycles still to spend in EXIT/ENTRY.
   logic [2:0] m_mode, nm;
   int         m_left, nl;
   logic [3:0] m_zone, nz, s1, s2;
   logic       m_j, m_k, nj, nk;

   always_comb begin
      nm = m_mode;
      nl = m_left;
      nz = m_zone;
      case (m_mode)
         3'd0: if (arm) begin nm = 3'd1; nl = EXIT_CYC; nz = 4'd0; end
         3'd1: if (code_ok) nm = 3'd0;
               else begin nl = m_left - 1; if (nl == 0) nm = 3'd2; end
         3'd2: if (code_ok) nm = 3'd0;
               else if (s2 != 4'd0) begin nm = 3'd3; nl = ENTRY_CYC; nz = m_zone | s2; end
         3'd3: if (code_ok) nm = 3'd0;
               else begin nz = m_zone | s2; nl = m_left - 1; if (nl == 0) nm = 3'd4; end
         3'd4: if (code_ok) nm = 3'd0; else nz = m_zone | s2;
         default: nm = 3'd0;
      endcase
      nj = (nm == 3'd4) && (m_mode != 3'd4);
      nk = (nm == 3'd0) && (m_mode == 3'd4);
   end

   always @(posedge clk or posedge clear) begin
      if (clear) begin
         m_mode <= 3'd0; m_left <= 0; m_zone <= 4'd0;
         m_j <= 1'b0; m_k <= 1'b0; s1 <= 4'd0; s2 <= 4'd0;
      end else begin
         m_mode <= nm; m_left <= nl; m_zone <= nz;
         m_j <= nj; m_k <= nk; s1 <= sensor; s2 <= s1;
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m_state", 8'(state), 8'(m_mode));
         chk("m_armed", 8'(armed), 8'((m_mode == 3'd2) || (m_mode == 3'd3)));
         chk("m_beep",  8'(beep),  8'((m_mode == 3'd1) || (m_mode == 3'd3)));
         chk("m_zone",  8'(zone),  8'(m_zone));
         chk("m_j",     8'(j),     8'(m_j));
         chk("m_k",     8'(k),     8'(m_k));
         chk("jk_excl", 8'(j & k), 8'd0);
      end
   end

   // Apply inputs for one rising edge; returns at the following falling edge.
   task automatic cyc(input logic a, input logic c, input logic [3:0] s);
      arm = a; code_ok = c; sensor = s;
      @(posedge clk);
      @(negedge clk);
      $display("cyc arm=%0b code_ok=%0b sensor=%b -> state=%0d armed=%0b beep=%0b j=%0b k=%0b zone=%b",
               a, c, s, state, armed, beep, j, k, zone);
   endtask

   task automatic to_armed();
      cyc(1'b1, 1'b0, 4'd0);
      repeat (EXIT_CYC) cyc(1'b0, 1'b0, 4'd0);
   endtask

   initial begin
      #1 clear = 1'b1;
      cmp_en = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_state", 8'(state), 8'd0);
      chk("rst_zone",  8'(zone),  8'd0);
      chk("rst_jk",    8'({j, k}), 8'd0);
      chk("rst_armed_beep", 8'({armed, beep}), 8'd0);
      clear = 1'b0;

      // Exit delay; a sensor trip and a stray arm during EXIT are ignored.
      cyc(1'b1, 1'b0, 4'd0);
      chk("exit_state", 8'(state), 8'd1);
      chk("exit_beep",  8'(beep),  8'd1);
      cyc(1'b0, 1'b0, 4'b1000);
      cyc(1'b1, 1'b0, 4'd0);
      cyc(1'b0, 1'b0, 4'd0);
      chk("exit_last_state", 8'(state), 8'd1);
      chk("exit_zone",       8'(zone),  8'd0);
      cyc(1'b0, 1'b0, 4'd0);
      chk("armed_state", 8'(state), 8'd2);
      chk("armed_flags", 8'({armed, beep}), 8'b10);
      cyc(1'b0, 1'b0, 4'd0);
      chk("armed_hold",  8'(state), 8'd2);

      // Sensor trip -> ENTRY two edges later -> ALARM after the entry delay.
      cyc(1'b0, 1'b0, 4'b0010);
      cyc(1'b0, 1'b0, 4'b0010);
      chk("entry_pending", 8'(state), 8'd2);
      cyc(1'b0, 1'b0, 4'b0010);
      chk("entry_state", 8'(state), 8'd3);
      chk("entry_zone",  8'(zone),  8'b0010);
      cyc(1'b0, 1'b0, 4'b0010);
      cyc(1'b0, 1'b0, 4'b0010);
      chk("entry_last", 8'(state), 8'd3);
      cyc(1'b0, 1'b0, 4'b0010);
      chk("alarm_state", 8'(state), 8'd4);
      chk("alarm_jk",    8'({j, k}), 8'b10);
      cyc(1'b0, 1'b0, 4'd0);
      chk("alarm_j_once", 8'({j, k}), 8'b00);
      chk("alarm_zone",   8'(zone),   8'b0010);

      // Disarm from ALARM: one k pulse, zone retained.
      cyc(1'b0, 1'b1, 4'd0);
      chk("disarm_state", 8'(state), 8'd0);
      chk("disarm_jk",    8'({j, k}), 8'b01);
      chk("disarm_zone",  8'(zone),   8'b0010);
      cyc(1'b0, 1'b0, 4'd0);
      chk("disarm_k_once", 8'(k), 8'd0);

      // code_ok coincident with entry expiry wins; no j, no k.
      to_armed();
      repeat (3) cyc(1'b0, 1'b0, 4'b0001);
      chk("e2_entry", 8'(state), 8'd3);
      repeat (2) cyc(1'b0, 1'b0, 4'b0001);
      cyc(1'b0, 1'b1, 4'b0001);
      chk("e2_state", 8'(state), 8'd0);
      chk("e2_jk",    8'({j, k}), 8'b00);
      chk("e2_zone",  8'(zone),   8'b0001);
      cyc(1'b0, 1'b0, 4'd0);
      chk("e2_no_k", 8'({j, k}), 8'b00);

      // Asynchronous clear in the middle of ALARM.
      to_armed();
      repeat (6) cyc(1'b0, 1'b0, 4'b0100);
      chk("c_alarm", 8'(state), 8'd4);
      cyc(1'b0, 1'b0, 4'd0);
      #1 clear = 1'b1;
      #2;
      chk("c_state", 8'(state), 8'd0);
      chk("c_jk",    8'({j, k}), 8'b00);
      chk("c_zone",  8'(zone),   8'd0);
      #1 clear = 1'b0;
      cyc(1'b1, 1'b0, 4'd0);
      chk("c_rearm", 8'(state), 8'd1);
      chk("c_no_k",  8'(k),     8'd0);

      // Random traffic; the per-cycle model comparison does the checking.
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alarm_fsm.md
ALARM_FSM -- requirements
Module: alarm_fsm

Interface
REQ-001 Parameter EXIT_CYC, default 16, exit-delay length in clk cycles (1..255).
REQ-002 Parameter ENTRY_CYC, default 8, entry-delay length in clk cycles (1..255).
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 clear  input  1  asynchronous, active-high reset.
REQ-005 arm  input  1  one-cycle arm request from keypad logic (synchronous to clk).
REQ-006 code_ok  input  1  one-cycle "valid user code entered" pulse (synchronous to clk).
REQ-007 sensor  input  4  raw asynchronous door/window sensors, 1 = open/tripped.
REQ-008 j  output  1  set command to the downstream siren ff_jk latch.
REQ-009 k  output  1  reset command to the downstream siren ff_jk latch.
REQ-010 state  output  3  current FSM state encoding.
REQ-011 armed  output  1  high in ARMED and ENTRY.
REQ-012 beep  output  1  warning buzzer, high in EXIT and ENTRY.
REQ-013 zone  output  4  latched record of sensors that tripped while armed.

Function
REQ-014 States: DISARMED=0, EXIT=1, ARMED=2, ENTRY=3, ALARM=4; codes 5..7 SHALL go to DISARMED on next edge.
REQ-015 sensor SHALL pass through a 2-flop synchronizer per bit; FSM uses synced value only (raw change at edge n acted on at edge n+2).
REQ-016 DISARMED: arm=1 -> EXIT, counter loads EXIT_CYC-1, zone clears to 0; sensors, code_ok ignored.
REQ-017 EXIT: counter!=0 -> decrement; counter==0 -> ARMED; EXIT lasts exactly EXIT_CYC cycles; sensors ignored.
REQ-018 ARMED: any synced sensor bit=1 -> ENTRY, counter loads ENTRY_CYC-1, zone |= synced sensor.
REQ-019 ENTRY: counter decrements as in EXIT; counter==0 -> ALARM; zone |= synced sensor every cycle.
REQ-020 ALARM: holds until code_ok; zone |= synced sensor every cycle.
REQ-021 code_ok=1 in EXIT, ARMED, ENTRY or ALARM -> DISARMED on that edge; zone retained.
REQ-022 Priority: code_ok over counter expiry, sensor and arm; arm outside DISARMED ignored.
REQ-023 j SHALL be 1 (k=0) for exactly one cycle, the first cycle state reads ALARM.
REQ-024 k SHALL be 1 (j=0) for exactly one cycle, the first cycle state reads DISARMED after leaving ALARM; leaving EXIT/ARMED/ENTRY gives no k pulse.
REQ-025 j and k SHALL never be 1 together; otherwise j=k=0 (ff_jk hold).
REQ-026 All outputs registered; armed, beep decoded from registered state only.
REQ-027 Counter 8 bits, no wrap: never decremented below 0.

Reset
REQ-028 clear=1 SHALL immediately, independent of clk: state=DISARMED, counter=0, j=0, k=0, armed=0, beep=0, zone=0, synchronizer flops=0.
REQ-029 clear asserted mid-EXIT/ENTRY/ALARM SHALL abort with no j/k pulse; after release, first edge evaluates from DISARMED.
REQ-030 clear has priority over every input, including a coincident clk edge.

Verification (EXIT_CYC=4, ENTRY_CYC=3)
REQ-031 arm pulse at edge 0 -> state=1, beep=1 for edges 0..3 outputs; state=2, armed=1, beep=0 after edge 4.
REQ-032 Armed, sensor=4'b0010 raised before edge n -> state=3 after n+2, state=4 with j=1 one cycle after n+5, zone=4'b0010.
REQ-033 In ALARM, code_ok pulse -> state=0, k=1 for one cycle, j=0, zone still 4'b0010; next cycle k=0.
REQ-034 In ENTRY with counter=0, code_ok and expiry same edge -> state=0, j=0, k=0; sensor 4'b1000 tripped during EXIT -> no transition, zone=0.
REQ-035 clear pulse mid-ALARM between edges -> state=0, j=k=0, zone=0 before next edge; arm after release re-enters EXIT normally.
REQ-036 Force state=6 -> state=0 after one edge; j=k never simultaneously 1 across random stimulus (assertion).
